// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between WB and a queued multi-cycle unit
// Optional ARB_PERF_CNT_EN adds a saturating stall_cnt of forced-stall cycles.
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [3:0]  wb_a,
    input  logic [31:0] wb_wd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [3:0]  mc_a,
    input  logic [31:0] mc_wd,
    input  logic [3:0]  rd_a1,
    input  logic [3:0]  rd_a2,
    output logic        pend_hit,
    output logic        stall,
    output logic        we3,
    output logic [3:0]  a3,
    output logic [31:0] wd3,
    output logic        r15_drop
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [3:0]        fifo_a  [FIFO_DEPTH];
    logic [31:0]       fifo_wd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic [SW-1:0]     starve, starve_next;

    logic fifo_empty, mc_hs, mc_push, mc_drop;
    logic forcing, wb_live, wb_grant, wb_drop, head_grant;

    assign fifo_empty = (count == '0);
    assign mc_ready   = (count < CW'(FIFO_DEPTH));
    assign mc_hs      = mc_valid & mc_ready;
    assign mc_push    = mc_hs & (mc_a != 4'd15);
    assign mc_drop    = mc_hs & (mc_a == 4'd15);

    // During a forced stall the pipeline re-presents its WB request next cycle.
    assign forcing    = (state == FORCE);
    assign wb_live    = wb_we & ~forcing;
    assign wb_grant   = wb_live & (wb_a != 4'd15);
    assign wb_drop    = wb_live & (wb_a == 4'd15);
    assign head_grant = ~fifo_empty & (forcing | ~wb_grant);
    assign stall      = forcing;

    always_comb begin
        count_next = count;
        if (mc_push && !head_grant) begin
            count_next = count + CW'(1);
        end else if (!mc_push && head_grant) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        starve_next = starve;
        if (fifo_empty || head_grant) begin
            starve_next = '0;
        end else if (starve < SW'(STARVE_LIMIT)) begin
            starve_next = starve + SW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mc_push) state_next = DRAIN;
            end
            DRAIN: begin
                if (starve_next == SW'(STARVE_LIMIT)) state_next = FORCE;
                else if (count_next == '0)             state_next = IDLE;
            end
            FORCE: begin
                state_next = (count_next == '0) ? IDLE : DRAIN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            starve   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_vld <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            starve <= starve_next;
            if (head_grant) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (mc_push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PW'(1);
            end
        end
    end

    // Payload storage needs no reset; validity lives in fifo_vld.
    always_ff @(posedge clk) begin
        if (mc_push) begin
            fifo_a[wr_ptr]  <= mc_a;
            fifo_wd[wr_ptr] <= mc_wd;
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_a[i] != 4'd15) &&
                ((fifo_a[i] == rd_a1) || (fifo_a[i] == rd_a2))) begin
                pend_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            r15_drop <= 1'b0;
        end else begin
            we3      <= wb_grant | head_grant;
            r15_drop <= wb_drop | mc_drop;
            if (wb_grant) begin
                a3  <= wb_a;
                wd3 <= wb_wd;
            end else if (head_grant) begin
                a3  <= fifo_a[rd_ptr];
                wd3 <= fifo_wd[rd_ptr];
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (forcing && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [3:0]  wb_a;
    logic [31:0] wb_wd;
    logic        mc_valid;
    logic        mc_ready;
    logic [3:0]  mc_a;
    logic [31:0] mc_wd;
    logic [3:0]  rd_a1;
    logic [3:0]  rd_a2;
    logic        pend_hit;
    logic        stall;
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        r15_drop;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_a     (wb_a),
        .wb_wd    (wb_wd),
        .mc_valid (mc_valid),
        .mc_ready (mc_ready),
        .mc_a     (mc_a),
        .mc_wd    (mc_wd),
        .rd_a1    (rd_a1),
        .rd_a2    (rd_a2),
        .pend_hit (pend_hit),
        .stall    (stall),
        .we3      (we3),
        .a3       (a3),
        .wd3      (wd3),
        .r15_drop (r15_drop)
`ifdef ARB_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] wd;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] wd);
        wr_t e;
        e.a  = a;
        e.wd = wd;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && we3 === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_write observed=a3:%0h wd3:%0h expected=no write", a3, wd3);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_a3", 32'(a3), 32'(mon_e.a));
                chk("wr_wd3", wd3, mon_e.wd);
            end
        end
    end

    initial begin
        int w;
        reset = 1'b0; wb_we = 1'b0; wb_a = '0; wb_wd = '0;
        mc_valid = 1'b0; mc_a = '0; mc_wd = '0; rd_a1 = '0; rd_a2 = '0;
        #2 reset = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pend", 32'(pend_hit), 32'd0);
        chk("rst_ready", 32'(mc_ready), 32'd1);
        chk("rst_r15", 32'(r15_drop), 32'd0);
        chk("rst_a3", 32'(a3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // WB write lands exactly one cycle later
        step();
        wb_we = 1'b1; wb_a = 4'd3; wb_wd = 32'h55; expect_wr(4'd3, 32'h55);
        @(negedge clk); chk("t1_pre_we3", 32'(we3), 32'd0);
        step(); wb_we = 1'b0;
        @(negedge clk); chk("t1_we3", 32'(we3), 32'd1);
        step();
        @(negedge clk); chk("t1_after_we3", 32'(we3), 32'd0);

        // MC push: pending for one cycle, written two cycles later
        step();
        mc_valid = 1'b1; mc_a = 4'd5; mc_wd = 32'hAA; rd_a1 = 4'd5; expect_wr(4'd5, 32'hAA);
        @(negedge clk);
        chk("t2_ready", 32'(mc_ready), 32'd1);
        chk("t2_pend_pre", 32'(pend_hit), 32'd0);
        step(); mc_valid = 1'b0;
        @(negedge clk);
        chk("t2_pend", 32'(pend_hit), 32'd1);
        chk("t2_we3_n1", 32'(we3), 32'd0);
        step();
        @(negedge clk);
        chk("t2_we3_n2", 32'(we3), 32'd1);
        chk("t2_pend_after", 32'(pend_hit), 32'd0);
        rd_a1 = 4'd0;

        // Starvation: WB held, FIFO fills, forced stall after 8 waiting cycles
        w = 0;
        for (int k = 0; k <= 10; k++) begin
            step();
            wb_we = 1'b1; wb_a = 4'd1; wb_wd = 32'h200 + 32'(w);
            if (k < 4) begin
                mc_valid = 1'b1; mc_a = 4'(8 + k); mc_wd = 32'h100 + 32'(k);
            end else begin
                mc_valid = 1'b0;
            end
            if (k == 9) begin
                expect_wr(4'd8, 32'h100);
            end else begin
                expect_wr(4'd1, 32'h200 + 32'(w));
                w++;
            end
            @(negedge clk);
            chk($sformatf("t3_stall_c%0d", k), 32'(stall), (k == 9) ? 32'd1 : 32'd0);
            if (k < 4)   chk($sformatf("t3_ready_c%0d", k), 32'(mc_ready), 32'd1);
            if (k == 4)  chk("t3_full", 32'(mc_ready), 32'd0);
            if (k == 10) chk("t3_ready_again", 32'(mc_ready), 32'd1);
        end
        step();
        wb_we = 1'b0; rd_a1 = 4'd11;
        expect_wr(4'd9, 32'h101); expect_wr(4'd10, 32'h102); expect_wr(4'd11, 32'h103);
        @(negedge clk); chk("t3_pend11", 32'(pend_hit), 32'd1);
        step(); step(); step();
        @(negedge clk);
        chk("t3_pend_drained", 32'(pend_hit), 32'd0);
        chk("t3_stall_idle", 32'(stall), 32'd0);
`ifdef ARB_PERF_CNT_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd1);
`endif
        rd_a1 = 4'd0;
        step();

        // R15 writes are discarded
        step();
        wb_we = 1'b1; wb_a = 4'd15; wb_wd = 32'hDEAD;
        step(); wb_we = 1'b0;
        @(negedge clk);
        chk("t4_wb15_we3", 32'(we3), 32'd0);
        chk("t4_wb15_drop", 32'(r15_drop), 32'd1);
        step();
        @(negedge clk); chk("t4_drop_pulse_end", 32'(r15_drop), 32'd0);
        step();
        mc_valid = 1'b1; mc_a = 4'd15; mc_wd = 32'h77; rd_a1 = 4'd15;
        @(negedge clk); chk("t4_mc15_ready", 32'(mc_ready), 32'd1);
        step(); mc_valid = 1'b0;
        @(negedge clk);
        chk("t4_mc15_drop", 32'(r15_drop), 32'd1);
        chk("t4_mc15_pend", 32'(pend_hit), 32'd0);
        step();
        @(negedge clk);
        chk("t4_mc15_we3", 32'(we3), 32'd0);
        chk("t4_mc15_drop_end", 32'(r15_drop), 32'd0);
        rd_a1 = 4'd0;
        step();
        mc_valid = 1'b1; mc_a = 4'd6; mc_wd = 32'h66; expect_wr(4'd6, 32'h66);
        step();
        mc_valid = 1'b0; wb_we = 1'b1; wb_a = 4'd15; wb_wd = 32'hBEEF;
        step(); wb_we = 1'b0;
        @(negedge clk);
        chk("t4_slot_we3", 32'(we3), 32'd1);
        chk("t4_slot_drop", 32'(r15_drop), 32'd1);

        // Same register from WB and MC in one cycle: WB first
        step();
        wb_we = 1'b1; wb_a = 4'd7; wb_wd = 32'd1;
        mc_valid = 1'b1; mc_a = 4'd7; mc_wd = 32'd2;
        expect_wr(4'd7, 32'd1); expect_wr(4'd7, 32'd2);
        step();
        wb_we = 1'b0; mc_valid = 1'b0; rd_a2 = 4'd7;
        @(negedge clk);
        chk("t5_pend", 32'(pend_hit), 32'd1);
        chk("t5_first_wd3", wd3, 32'd1);
        step();
        @(negedge clk); chk("t5_second_wd3", wd3, 32'd2);
        rd_a2 = 4'd0;
        step();

        // Reset with three queued entries loses them
        rd_a1 = 4'd14;
        for (int k = 0; k < 4; k++) begin
            step();
            wb_we = 1'b1; wb_a = 4'd2; wb_wd = 32'h300 + 32'(k);
            if (k < 3) begin
                mc_valid = 1'b1; mc_a = 4'(12 + k); mc_wd = 32'h400 + 32'(k);
                expect_wr(4'd2, 32'h300 + 32'(k));
            end else begin
                mc_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("t6_pend_pre", 32'(pend_hit), 32'd1);
        chk("t6_ready_pre", 32'(mc_ready), 32'd1);
        step();
        wb_we = 1'b0; mc_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("t6_we3", 32'(we3), 32'd0);
        chk("t6_stall", 32'(stall), 32'd0);
        chk("t6_pend", 32'(pend_hit), 32'd0);
        chk("t6_ready", 32'(mc_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("t6_no_write_c%0d", k), 32'(we3), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
